// File: rtl/uart_rx_multi.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_multi
//   UART receiver with 2-flop input synchronizer, 3-sample majority voting,
//   false-start rejection, optional parity, 1/2 stop bits and a small
//   first-word-fall-through output FIFO with per-word error flags.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   rx_pin         asynchronous serial line, idle high
//   rx_data        head-of-FIFO data word (0 while FIFO empty)
//   rx_parity_err  head word failed parity check
//   rx_frame_err   head word had a low stop-bit sample
//   rx_data_valid  FIFO not empty
//   rx_data_ready  consumer accepts head word when high with valid
//   rx_overrun     one-cycle pulse: completed frame dropped, FIFO full
//   rx_busy        receive FSM not in IDLE
//
// FSM states
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for a falling edge on the synchronized line
//   S_START  | timing the start bit; voted 1 at mid-bit = false start
//   S_DATA   | shifting in DATA_BITS data bits, LSB first
//   S_PARITY | checking the parity bit (only when PARITY != 0)
//   S_STOP   | sampling stop bit(s); last one exits at mid-bit
//   S_PUSH   | one cycle: write frame into FIFO or flag overrun
// -----------------------------------------------------------------------------
module uart_rx_multi #(
  parameter int CLKS_PER_BIT = 240,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_data_valid,
  input  logic                 rx_data_ready,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;
  localparam int BW  = $clog2(DATA_BITS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int EW  = DATA_BITS + 2;

  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID_M1 = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_MID    = CW'(MID);
  localparam logic [CW-1:0] CNT_MID_P1 = CW'(MID + 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);
  localparam logic          PAR_ODD    = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_PUSH
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 rx_s_q, rx_s_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           samp_q, samp_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [EW-1:0]        mem_d [FIFO_DEPTH];

  logic          fall;
  logic          vote;
  logic          at_mid1;
  logic          at_last;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push_req;
  logic          push_ok;
  logic [EW-1:0] head;

  assign fall    = rx_prev_q & ~rx_s_q;
  // Third sample is the live synchronized value at cnt = MID+1.
  assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
  assign at_mid1 = (cnt_q == CNT_MID_P1);
  assign at_last = (cnt_q == CNT_LAST);

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = ~fifo_empty & rx_data_ready;
  assign push_req   = (state_q == S_PUSH);
  // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
  assign push_ok    = push_req & (~fifo_full | pop);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d    = state_q;
    sync1_d    = rx_pin;
    rx_s_d     = sync1_q;
    rx_prev_d  = rx_s_q;
    samp_d     = samp_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;

    if (cnt_q == CNT_MID_M1) samp_d[0] = rx_s_q;
    if (cnt_q == CNT_MID)    samp_d[1] = rx_s_q;

    case (state_q)
      S_IDLE: begin
        if (fall) state_d = S_START;
      end
      S_START: begin
        if (at_mid1 && vote) begin
          state_d = S_IDLE;
        end else if (at_last) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (at_mid1) shreg_d[bit_idx_q] = vote;
        if (at_last) begin
          if (bit_idx_q == BIT_LAST) begin
            state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (at_mid1 && ((^shreg_q ^ vote) != PAR_ODD)) perr_d = 1'b1;
        if (at_last) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
        end
      end
      S_STOP: begin
        if (at_mid1 && !vote) ferr_d = 1'b1;
        // Last stop bit exits at mid-bit so the next start edge is seen.
        if (at_mid1 && (stop_idx_q == STOP_LAST)) begin
          state_d = S_PUSH;
        end else if (at_last) begin
          stop_idx_d = stop_idx_q + 1'b1;
        end
      end
      S_PUSH: begin
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && (state_q != S_IDLE)) begin
      cnt_d = at_last ? '0 : cnt_q + CW'(1);
    end
  end

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = push_req & ~push_ok;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = {ferr_q, perr_q, shreg_q};
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      cnt_q      <= '0;
      samp_q     <= 2'b11;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      rx_s_q     <= rx_s_d;
      rx_prev_q  <= rx_prev_d;
      cnt_q      <= cnt_d;
      samp_q     <= samp_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_q      <= mem_d;
    end
  end

  // Outputs are forced to zero while empty so the reset view is all-zero.
  assign rx_data_valid = ~fifo_empty;
  assign rx_data       = fifo_empty ? '0 : head[DATA_BITS-1:0];
  assign rx_parity_err = ~fifo_empty & head[DATA_BITS];
  assign rx_frame_err  = ~fifo_empty & head[DATA_BITS+1];
  assign rx_overrun    = overrun_q;
  assign rx_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_multi.sv
`timescale 1ns/1ps
// Directed bench: three receiver instances (8N1, 8E1, 8N2) at 16 clk/bit
// share one stimulus line through a selector. A negedge monitor records
// every accepted word as {ferr, perr, data}.
module tb_uart_rx_multi;

  localparam int CPB = 16;
  localparam int MID = CPB / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic line;
  int   sel;
  logic pin_n1, pin_e1, pin_n2;
  logic rdy_n1, rdy_e1, rdy_n2;
  logic [7:0] data_n1, data_e1, data_n2;
  logic perr_n1, perr_e1, perr_n2;
  logic ferr_n1, ferr_e1, ferr_n2;
  logic vld_n1, vld_e1, vld_n2;
  logic ovr_n1, ovr_e1, ovr_n2;
  logic busy_n1, busy_e1, busy_n2;

  assign pin_n1 = (sel == 0) ? line : 1'b1;
  assign pin_e1 = (sel == 1) ? line : 1'b1;
  assign pin_n2 = (sel == 2) ? line : 1'b1;

  uart_rx_multi #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_n1 (
    .clk(clk), .rst_n(rst_n), .rx_pin(pin_n1), .rx_data(data_n1), .rx_parity_err(perr_n1),
    .rx_frame_err(ferr_n1), .rx_data_valid(vld_n1), .rx_data_ready(rdy_n1),
    .rx_overrun(ovr_n1), .rx_busy(busy_n1));

  uart_rx_multi #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e1 (
    .clk(clk), .rst_n(rst_n), .rx_pin(pin_e1), .rx_data(data_e1), .rx_parity_err(perr_e1),
    .rx_frame_err(ferr_e1), .rx_data_valid(vld_e1), .rx_data_ready(rdy_e1),
    .rx_overrun(ovr_e1), .rx_busy(busy_e1));

  uart_rx_multi #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_n2 (
    .clk(clk), .rst_n(rst_n), .rx_pin(pin_n2), .rx_data(data_n2), .rx_parity_err(perr_n2),
    .rx_frame_err(ferr_n2), .rx_data_valid(vld_n2), .rx_data_ready(rdy_n2),
    .rx_overrun(ovr_n2), .rx_busy(busy_n2));

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int start_cyc;
  int cap_cyc_n1;
  int ovr_cnt_n1 = 0;
  int ovr_cnt_oth = 0;
  bit busy_seen_n1 = 1'b0;
  logic [9:0] q_n1[$];
  logic [9:0] q_e1[$];
  logic [9:0] q_n2[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    #1;
    if (vld_n1 && rdy_n1) begin
      q_n1.push_back({ferr_n1, perr_n1, data_n1});
      cap_cyc_n1 = cyc;
    end
    if (vld_e1 && rdy_e1) q_e1.push_back({ferr_e1, perr_e1, data_e1});
    if (vld_n2 && rdy_n2) q_n2.push_back({ferr_n2, perr_n2, data_n2});
    if (ovr_n1) ovr_cnt_n1++;
    if (ovr_e1 || ovr_n2) ovr_cnt_oth++;
    if (busy_n1) busy_seen_n1 = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] pop_q(input int which);
    logic [9:0] w;
    w = 10'h3FF;
    case (which)
      0: if (q_n1.size() > 0) w = q_n1.pop_front();
      1: if (q_e1.size() > 0) w = q_e1.pop_front();
      default: if (q_n2.size() > 0) w = q_n2.pop_front();
    endcase
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends bits[0..n-1] LSB first, one bit per CPB clocks. glitch_bit inverts
  // that bit for the single clock that feeds the mid-bit (MID) sample.
  task automatic send_bits(input logic [15:0] bits, input int n, input int glitch_bit);
    start_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < CPB; j++) begin
        line = (glitch_bit == i && j == MID + 1) ? ~bits[i] : bits[i];
        @(negedge clk);
      end
    end
  endtask

  initial begin
    sel    = 0;
    line   = 1'b1;
    rdy_n1 = 1'b1;
    rdy_e1 = 1'b1;
    rdy_n2 = 1'b1;
    rst_n  = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    chk("reset_data", data_n1, 8'h00);
    chk("reset_flags_valid_busy", {perr_n1, ferr_n1, vld_n1, ovr_n1, busy_n1}, 5'b0);

    // 8N1 clean frame
    send_bits({1'b1, 8'hA5, 1'b0}, 10, -1);
    idle(5);
    chk("a5_count", q_n1.size(), 1);
    chk("a5_word", pop_q(0), {2'b00, 8'hA5});
    chk("a5_latency_window", ((cap_cyc_n1 - start_cyc) >= 156) && ((cap_cyc_n1 - start_cyc) <= 159), 1);

    // 8E1: 0x01 with parity 0 is a mismatch, 0x03 with parity 0 is fine
    sel = 1;
    send_bits({1'b1, 1'b0, 8'h01, 1'b0}, 11, -1);
    send_bits({1'b1, 1'b0, 8'h03, 1'b0}, 11, -1);
    idle(5);
    chk("e1_count", q_e1.size(), 2);
    chk("e1_bad_parity", pop_q(1), {2'b01, 8'h01});
    chk("e1_good_parity", pop_q(1), {2'b00, 8'h03});

    // 8N2: second stop bit low
    sel = 2;
    send_bits({1'b0, 1'b1, 8'h3C, 1'b0}, 11, -1);
    line = 1'b1;
    idle(20);
    chk("n2_count", q_n2.size(), 1);
    chk("n2_frame_err", pop_q(2), {2'b10, 8'h3C});

    // Break: all-zero data with low stop bit, no spurious second frame
    sel = 0;
    idle(2);
    send_bits({1'b0, 8'h00, 1'b0}, 10, -1);
    idle(40);
    line = 1'b1;
    idle(40);
    chk("break_count", q_n1.size(), 1);
    chk("break_word", pop_q(0), {2'b10, 8'h00});

    // Start-edge latency and false-start rejection (4-cycle low glitch)
    busy_seen_n1 = 1'b0;
    line = 1'b0;
    idle(2);
    chk("start_edge_not_yet", busy_n1, 1'b0);
    idle(1);
    chk("start_edge_3_edges", busy_n1, 1'b1);
    idle(1);
    line = 1'b1;
    idle(30);
    chk("glitch_busy_seen", busy_seen_n1, 1'b1);
    chk("glitch_idle_again", busy_n1, 1'b0);
    chk("glitch_no_word", {vld_n1, 8'(q_n1.size())}, 9'h0);

    // Majority vote: single flipped MID sample inside data bit 3
    send_bits({1'b1, 8'h5A, 1'b0}, 10, 4);
    idle(5);
    chk("vote_count", q_n1.size(), 1);
    chk("vote_word", pop_q(0), {2'b00, 8'h5A});

    // Overrun: ready low, five back-to-back frames into a 4-deep FIFO
    rdy_n1 = 1'b0;
    ovr_cnt_n1 = 0;
    for (int k = 0; k < 4; k++) send_bits({1'b1, 8'(8'h10 + k), 1'b0}, 10, -1);
    chk("overrun_none_after_4", ovr_cnt_n1, 0);
    send_bits({1'b1, 8'h14, 1'b0}, 10, -1);
    idle(5);
    chk("overrun_one_pulse", ovr_cnt_n1, 1);
    chk("overrun_head_visible", {vld_n1, data_n1}, {1'b1, 8'h10});
    rdy_n1 = 1'b1;
    idle(10);
    chk("drain_count", q_n1.size(), 4);
    for (int k = 0; k < 4; k++) chk($sformatf("drain_word_%0d", k), pop_q(0), {2'b00, 8'(8'h10 + k)});
    chk("drain_valid_low", vld_n1, 1'b0);

    // Reset mid-frame: FIFO holds 0x77, 0xFF is cut during data bit 4
    rdy_n1 = 1'b0;
    send_bits({1'b1, 8'h77, 1'b0}, 10, -1);
    idle(5);
    send_bits({4'hF, 1'b0}, 5, -1);
    idle(MID);
    chk("midframe_busy", busy_n1, 1'b1);
    rst_n = 1'b0;
    idle(3);
    chk("reset_busy_clear", busy_n1, 1'b0);
    rst_n = 1'b1;
    idle(40);
    chk("reset_fifo_flushed", {vld_n1, busy_n1}, 2'b00);
    rdy_n1 = 1'b1;
    send_bits({1'b1, 8'h5A, 1'b0}, 10, -1);
    idle(10);
    chk("post_reset_count", q_n1.size(), 1);
    chk("post_reset_word", pop_q(0), {2'b00, 8'h5A});
    chk("other_overruns", ovr_cnt_oth, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
